// File: rtl/cycle_sequencer.sv
// cycle_sequencer: per-instruction cycle counter with run/pause/step control, halt, watchdog and retire count
module cycle_sequencer #(
  parameter int CNT_W = 3,
  parameter int MAX_STEP = 7,
  parameter int IC_W = 16
) (
  input  logic             clk,
  input  logic             Rst,
  input  logic             Run,
  input  logic             Step,
  input  logic             Buff_PC,
  input  logic             Done,
  output logic [CNT_W-1:0] Cnt,
  output logic             IR_load,
  output logic             Active,
  output logic             Paused,
  output logic             Halted,
  output logic             Fault,
  output logic [IC_W-1:0]  InsCount
);
  typedef enum logic [2:0] {IDLE, RUN, PAUSE, STEP, HALT, FAULT} state_t;
  localparam logic [CNT_W-1:0] MAX = CNT_W'(MAX_STEP);
  state_t state, state_n;
  logic [CNT_W-1:0] cnt_n;
  logic [IC_W-1:0] ic_n;
  logic step_d, step_edge;
  assign step_edge = Step & ~step_d;
  always_comb begin
    state_n = state;
    cnt_n = Cnt;
    ic_n = InsCount;
    case (state)
      IDLE: state_n = Run ? RUN : PAUSE;
      RUN, STEP: begin
        if (Buff_PC) begin
          cnt_n = '0;
          ic_n = InsCount + 1'b1;
          state_n = Done ? HALT : (state == STEP || !Run) ? PAUSE : RUN;
        end else if (Cnt == MAX) begin
          state_n = FAULT;
        end else begin
          cnt_n = Cnt + 1'b1;
        end
      end
      PAUSE: begin
        cnt_n = '0;
        state_n = Run ? RUN : step_edge ? STEP : PAUSE;
      end
      HALT: cnt_n = '0;
      default: ;
    endcase
  end
  always_ff @(posedge clk) begin
    if (Rst) begin
      state <= IDLE;
      Cnt <= '0;
      InsCount <= '0;
      step_d <= 1'b0;
    end else begin
      state <= state_n;
      Cnt <= cnt_n;
      InsCount <= ic_n;
      step_d <= Step;
    end
  end
  assign Active = (state == RUN) || (state == STEP);
  assign Paused = state == PAUSE;
  assign Halted = state == HALT;
  assign Fault = state == FAULT;
  assign IR_load = Active && (Cnt == '0);
endmodule

// File: tb/tb_cycle_sequencer.sv
// tb_cycle_sequencer: directed scenario tests for cycle_sequencer
module tb_cycle_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b0, run = 1'b0, step = 1'b0, buff_pc = 1'b0, done = 1'b0;
  logic [2:0] cnt;
  logic ir_load, active, paused, halted, fault;
  logic [15:0] ins_count;
  logic [4:0] flags;
  int checks = 0, errors = 0, ic = 0;
  assign flags = {active, paused, halted, fault, ir_load};

  cycle_sequencer dut (
    .clk(clk), .Rst(rst), .Run(run), .Step(step), .Buff_PC(buff_pc), .Done(done),
    .Cnt(cnt), .IR_load(ir_load), .Active(active), .Paused(paused), .Halted(halted),
    .Fault(fault), .InsCount(ins_count)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (cnt !== 3'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", cnt); end
    checks++;
    if (ins_count !== 16'd0) begin errors++; $display("FAIL reset_inscount: got %0d expected 0", ins_count); end
    checks++;
    if (flags !== 5'b00000) begin errors++; $display("FAIL reset_flags: got %b expected 00000", flags); end
    rst = 1'b0;
    run = 1'b1;
    tick();
    checks++;
    if (flags !== 5'b10001 || cnt !== 3'd0) begin errors++; $display("FAIL idle_to_run: flags %b cnt %0d expected 10001 cnt 0", flags, cnt); end
  endtask

  task automatic test_run;
    int exp = 0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (cnt !== 3'(exp) || ir_load !== (exp == 0)) begin errors++; $display("FAIL run_seq[%0d]: cnt %0d ir_load %b expected cnt %0d ir_load %b", i, cnt, ir_load, exp, exp == 0); end
      buff_pc = (exp == 3);
      tick();
      if (exp == 3) begin exp = 0; ic++; end else exp++;
      checks++;
      if (ins_count !== 16'(ic)) begin errors++; $display("FAIL run_inscount[%0d]: got %0d expected %0d", i, ins_count, ic); end
    end
    buff_pc = 1'b0;
  endtask

  task automatic test_pause;
    tick();
    run = 1'b0;
    tick();
    checks++;
    if (cnt !== 3'd2 || flags !== 5'b10000) begin errors++; $display("FAIL pause_continue: cnt %0d flags %b expected cnt 2 flags 10000", cnt, flags); end
    tick();
    checks++;
    if (cnt !== 3'd3 || !active) begin errors++; $display("FAIL pause_continue3: cnt %0d active %b expected cnt 3 active 1", cnt, active); end
    buff_pc = 1'b1;
    tick();
    ic++;
    buff_pc = 1'b0;
    checks++;
    if (flags !== 5'b01000 || cnt !== 3'd0 || ins_count !== 16'(ic)) begin errors++; $display("FAIL pause_enter: flags %b cnt %0d ins %0d expected 01000 0 %0d", flags, cnt, ins_count, ic); end
    repeat (3) tick();
    checks++;
    if (flags !== 5'b01000 || cnt !== 3'd0) begin errors++; $display("FAIL pause_hold: flags %b cnt %0d expected 01000 0", flags, cnt); end
    run = 1'b1;
    tick();
    checks++;
    if (flags !== 5'b10001 || cnt !== 3'd0) begin errors++; $display("FAIL pause_resume: flags %b cnt %0d expected 10001 0", flags, cnt); end
  endtask

  task automatic test_step;
    int n = 0;
    run = 1'b0;
    buff_pc = 1'b1;
    tick();
    ic++;
    buff_pc = 1'b0;
    step = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (active) n++;
      buff_pc = active && cnt == 3'd2;
    end
    ic++;
    checks++;
    if (n !== 3) begin errors++; $display("FAIL step_cycles: got %0d active cycles expected 3", n); end
    checks++;
    if (!paused || ins_count !== 16'(ic)) begin errors++; $display("FAIL step_retire: paused %b ins %0d expected paused 1 ins %0d", paused, ins_count, ic); end
    step = 1'b0;
    tick();
    step = 1'b1;
    tick();
    checks++;
    if (flags !== 5'b10001 || cnt !== 3'd0) begin errors++; $display("FAIL step_second: flags %b cnt %0d expected 10001 0", flags, cnt); end
    buff_pc = 1'b1;
    tick();
    ic++;
    buff_pc = 1'b0;
    step = 1'b0;
    checks++;
    if (!paused || ins_count !== 16'(ic)) begin errors++; $display("FAIL step_second_done: paused %b ins %0d expected paused 1 ins %0d", paused, ins_count, ic); end
  endtask

  task automatic test_halt;
    run = 1'b1;
    tick();
    repeat (4) tick();
    checks++;
    if (cnt !== 3'd4) begin errors++; $display("FAIL halt_pre_cnt: got %0d expected 4", cnt); end
    buff_pc = 1'b1;
    done = 1'b1;
    tick();
    ic++;
    checks++;
    if (flags !== 5'b00100 || cnt !== 3'd0 || ins_count !== 16'(ic)) begin errors++; $display("FAIL halt_enter: flags %b cnt %0d ins %0d expected 00100 0 %0d", flags, cnt, ins_count, ic); end
    done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      run = i[0];
      step = i[1];
      tick();
      checks++;
      if (flags !== 5'b00100 || cnt !== 3'd0 || ins_count !== 16'(ic)) begin errors++; $display("FAIL halt_stuck[%0d]: flags %b cnt %0d ins %0d expected 00100 0 %0d", i, flags, cnt, ins_count, ic); end
    end
    rst = 1'b1;
    tick();
    ic = 0;
    checks++;
    if (flags !== 5'b00000 || ins_count !== 16'd0) begin errors++; $display("FAIL halt_reset: flags %b ins %0d expected 00000 0", flags, ins_count); end
    rst = 1'b0;
    buff_pc = 1'b0;
    run = 1'b1;
    step = 1'b0;
  endtask

  task automatic test_watchdog;
    tick();
    for (int i = 1; i <= 7; i++) begin
      tick();
      checks++;
      if (cnt !== 3'(i) || !active) begin errors++; $display("FAIL wd_count[%0d]: cnt %0d active %b expected cnt %0d active 1", i, cnt, active, i); end
    end
    tick();
    checks++;
    if (flags !== 5'b00010 || cnt !== 3'd7) begin errors++; $display("FAIL wd_trip: flags %b cnt %0d expected 00010 7", flags, cnt); end
    repeat (2) tick();
    checks++;
    if (flags !== 5'b00010 || cnt !== 3'd7 || ins_count !== 16'd0) begin errors++; $display("FAIL wd_frozen: flags %b cnt %0d ins %0d expected 00010 7 0", flags, cnt, ins_count); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    repeat (7) tick();
    checks++;
    if (cnt !== 3'd7 || !active) begin errors++; $display("FAIL wd_edge_pre: cnt %0d active %b expected 7 1", cnt, active); end
    buff_pc = 1'b1;
    tick();
    ic = 1;
    checks++;
    if (flags !== 5'b10001 || cnt !== 3'd0 || ins_count !== 16'd1) begin errors++; $display("FAIL wd_edge_retire: flags %b cnt %0d ins %0d expected 10001 0 1", flags, cnt, ins_count); end
  endtask

  task automatic test_wrap_reset;
    repeat (65534) tick();
    checks++;
    if (ins_count !== 16'hFFFF) begin errors++; $display("FAIL wrap_pre: got %0d expected 65535", ins_count); end
    tick();
    checks++;
    if (ins_count !== 16'd0) begin errors++; $display("FAIL wrap_zero: got %0d expected 0", ins_count); end
    tick();
    buff_pc = 1'b0;
    tick();
    tick();
    checks++;
    if (cnt !== 3'd2 || ins_count !== 16'd1) begin errors++; $display("FAIL reset_pre: cnt %0d ins %0d expected 2 1", cnt, ins_count); end
    rst = 1'b1;
    buff_pc = 1'b1;
    tick();
    checks++;
    if (cnt !== 3'd0 || ins_count !== 16'd0 || flags !== 5'b00000) begin errors++; $display("FAIL reset_mid: cnt %0d ins %0d flags %b expected 0 0 00000", cnt, ins_count, flags); end
    rst = 1'b0;
    buff_pc = 1'b0;
  endtask

  initial begin
    test_reset();
    test_run();
    test_pause();
    test_step();
    test_halt();
    test_watchdog();
    test_wrap_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cycle_sequencer.md
Name: cycle_sequencer

Overview:
Central step sequencer for the multicycle RISC core. Generates the per-instruction cycle count Cnt consumed by InsDecoder and restarts it at each instruction boundary (Buff_PC). Adds run/pause/single-step control, halt on HLT (Done), a watchdog against a missing Buff_PC, and a retired-instruction counter. It sits between the board-level run/step controls and the decoder/datapath enables.

Parameters:
CNT_W, 3, width of Cnt
MAX_STEP, 7, highest legal Cnt value; reaching it without Buff_PC is a fault (must be ≤ 2^CNT_W-1)
IC_W, 16, width of InsCount

Ports:
clk  in  1  system clock, all state changes on rising edge
Rst  in  1  synchronous active-high reset
Run  in  1  level; 1 = free-run, 0 = pause at next instruction boundary
Step  in  1  single-step request; rising edge detected internally
Buff_PC  in  1  from InsDecoder; last cycle of the current instruction
Done  in  1  from InsDecoder; HLT executing (qualified by Buff_PC)
Cnt  out  CNT_W  cycle index within instruction, to InsDecoder
IR_load  out  1  instruction-register load enable (fetch cycle)
Active  out  1  datapath enable; 1 in RUN or STEP
Paused  out  1  1 in PAUSE
Halted  out  1  1 in HALT
Fault  out  1  1 in FAULT (watchdog tripped)
InsCount  out  IC_W  retired instructions, wraps 2^IC_W-1 -> 0

Behaviour:
- States: IDLE, RUN, PAUSE, STEP, HALT, FAULT. All registers update on posedge clk; Rst has priority over every other input.
- Reset: state=IDLE, Cnt=0, InsCount=0, Step_d=0. All flag outputs are 0 while in IDLE.
- IDLE: advances after exactly one cycle; Run=1 -> RUN, else -> PAUSE.
- Executing states (RUN/STEP), per cycle:
  - Buff_PC=1: Cnt<=0; InsCount<=InsCount+1. Next state: HALT if Done=1; else in RUN, PAUSE if Run=0 and RUN otherwise; in STEP, PAUSE.
  - Buff_PC=0, Cnt<MAX_STEP: Cnt<=Cnt+1, same state.
  - Buff_PC=0, Cnt==MAX_STEP: -> FAULT, Cnt held at MAX_STEP, InsCount unchanged.
  - Buff_PC=1 with Cnt==MAX_STEP in the same cycle: Buff_PC wins, no fault.
  - Done=1 with Buff_PC=0: ignored.
- Run deasserted mid-instruction: the instruction completes; pause takes effect only at Buff_PC. The sequencer never stops with Cnt≠0 except in FAULT.
- PAUSE: Cnt held 0.
  - Run=1 -> RUN next cycle. Run has priority over a simultaneous step edge.
  - Else a step edge (Step & ~Step_d) -> STEP.
  - Buff_PC and Done are ignored.
- Step edge detection: Step_d registers Step every cycle in all states. Step held high yields exactly one instruction. Step edges outside PAUSE are discarded, not queued.
- HALT: Cnt=0, Halted=1, Active=0. Exits only via Rst.
- FAULT: Fault=1, Active=0, Cnt frozen. Exits only via Rst.
- IR_load = Active & (Cnt==0), a decode of registered state, so no input-to-output combinational path. The decoder receives the instruction at Cnt==1.
- Active, Paused, Halted, Fault are one-hot decodes of state. All are 0 in IDLE.
- Reset mid-instruction: next cycle Cnt=0, InsCount=0, state IDLE, with no retire counted.

Test Plan:
- Reset then run: Rst=1 for 2 cycles, Run=1, Buff_PC pulses when Cnt==3 -> Cnt sequence 0,1,2,3,0,1…; IR_load=1 exactly when Cnt==0; InsCount increments 1 per Buff_PC.
- Pause at boundary: Run->0 while Cnt==1 -> Cnt continues 2,3, Buff_PC at 3, then Paused=1 with Cnt=0 held; Run->1 -> Active=1 one cycle later.
- Single step: in PAUSE, Step held high 10 cycles, Buff_PC at Cnt==2 -> exactly one instruction (Cnt 0,1,2), InsCount+1, returns to PAUSE; second Step edge -> another one.
- Halt: Buff_PC=1 with Done=1 at Cnt==4 -> Halted=1, Cnt=0, InsCount+1; subsequent Run/Step/Buff_PC have no effect until Rst=1.
- Watchdog: hold Buff_PC=0 -> Cnt 0..7, then Fault=1, Cnt stays 7. Separately, Buff_PC=1 at Cnt==7 -> no fault, Cnt=0.
- Wrap and reset priority: preload via 65536 retires -> InsCount wraps to 0. Rst=1 with Run=1 at Cnt==2 -> IDLE, Cnt=0, InsCount=0.
